// File: rtl/rep_str_seq_pkg.sv
// Shared execute-stage definitions for the repeated string sequencer:
// state, rep-prefix and operand-size encodings plus pointer step constants.
package rep_str_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHK    = 3'd1,
        ST_RD_SRC = 3'd2,
        ST_RD_DST = 3'd3,
        ST_CMP    = 3'd4,
        ST_UPD    = 3'd5,
        ST_DONE   = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        REP_NONE = 2'b00,
        REP_E    = 2'b01,
        REP_NE   = 2'b10,
        REP_RSVD = 2'b11
    } rep_mode_e;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'b00,
        SZ_WORD  = 2'b01,
        SZ_DWORD = 2'b10,
        SZ_RSVD  = 2'b11
    } op_size_e;

    localparam logic [2:0] DELTA_BYTE  = 3'd1;
    localparam logic [2:0] DELTA_WORD  = 3'd2;
    localparam logic [2:0] DELTA_DWORD = 3'd4;

    // Magnitude of the pointer step; the unused size code steps like a byte.
    function automatic logic [2:0] delta_mag(input op_size_e sz);
        case (sz)
            SZ_WORD:  delta_mag = DELTA_WORD;
            SZ_DWORD: delta_mag = DELTA_DWORD;
            default:  delta_mag = DELTA_BYTE;
        endcase
    endfunction

endpackage

// File: rtl/rep_str_seq_ptr_step.sv
// str_ptr_step: size/direction dependent delta generation plus pointer add.
// Subtracting the magnitude equals adding its two's complement; wraps mod 2^ADDR_W.
module str_ptr_step
    import rep_str_seq_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] ptr_i,
    input  op_size_e          size_i,
    input  logic              df_i,
    output logic [ADDR_W-1:0] ptr_o
);

    logic [ADDR_W-1:0] mag;

    assign mag   = ADDR_W'(delta_mag(size_i));
    assign ptr_o = df_i ? (ptr_i - mag) : (ptr_i + mag);

endmodule

// File: rtl/rep_str_seq.sv
// Sequencer for LODS/CMPS with optional REPE/REPNE prefix.
// Define REP_STR_REPNE_EN to decode rep_mode 10 as REPNE (otherwise it acts as REPE).
//
// Handshake: a read is requested while mem_req is high and holds mem_addr/mem_rd_size
// stable until the cycle mem_ack is high; that cycle completes the read (mem_out valid).
module rep_str_seq
    import rep_str_seq_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              op_cmps,
    input  logic [1:0]        rep_mode,
    input  logic [1:0]        op_size,
    input  logic              df,
    input  logic [ADDR_W-1:0] esi_in,
    input  logic [ADDR_W-1:0] edi_in,
    input  logic [CNT_W-1:0]  ecx_in,
    input  logic              mem_ack,
    input  logic              cmps_zf,
    output logic              busy,
    output logic              done,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_rd_size,
    output logic              latch_en,
    output logic              flags_ld,
    output logic [ADDR_W-1:0] esi_out,
    output logic [ADDR_W-1:0] edi_out,
    output logic [CNT_W-1:0]  ecx_out,
    output logic              wb_en,
    output logic [2:0]        dbg_state_o
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] esi_q, esi_d, edi_q, edi_d;
    logic [CNT_W-1:0]  ecx_q, ecx_d;
    logic              cmps_q, cmps_d;
    rep_mode_e         rep_q, rep_d;
    op_size_e          size_q, size_d;
    logic              df_q, df_d;
    logic              zf_q, zf_d;

    logic              busy_q, done_q, mem_req_q, flags_ld_q, wb_en_q;
    logic [ADDR_W-1:0] mem_addr_q;

    logic [ADDR_W-1:0] esi_step, edi_step;
    logic              rep_act, rep_ne, stop;

    str_ptr_step #(.ADDR_W(ADDR_W)) u_step_si (
        .ptr_i  (esi_q),
        .size_i (size_q),
        .df_i   (df_q),
        .ptr_o  (esi_step)
    );

    str_ptr_step #(.ADDR_W(ADDR_W)) u_step_di (
        .ptr_i  (edi_q),
        .size_i (size_q),
        .df_i   (df_q),
        .ptr_o  (edi_step)
    );

    assign rep_act = (rep_q == REP_E) || (rep_q == REP_NE);
`ifdef REP_STR_REPNE_EN
    assign rep_ne = (rep_q == REP_NE);
`else
    assign rep_ne = 1'b0;
`endif

    // ZF termination only applies to CMPS; LODS-style repeats stop on count alone.
    assign stop = !rep_act || (ecx_d == '0) ||
                  (cmps_q && (rep_ne ? zf_q : !zf_q));

    always_comb begin
        state_d = state_q;
        esi_d   = esi_q;
        edi_d   = edi_q;
        ecx_d   = ecx_q;
        cmps_d  = cmps_q;
        rep_d   = rep_q;
        size_d  = size_q;
        df_d    = df_q;
        zf_d    = zf_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    esi_d   = esi_in;
                    edi_d   = edi_in;
                    ecx_d   = ecx_in;
                    cmps_d  = op_cmps;
                    rep_d   = rep_mode_e'(rep_mode);
                    size_d  = op_size_e'(op_size);
                    df_d    = df;
                    zf_d    = 1'b0;
                    state_d = ST_CHK;
                end
            end
            ST_CHK:    state_d = (rep_act && ecx_q == '0) ? ST_DONE : ST_RD_SRC;
            ST_RD_SRC: if (mem_ack) state_d = cmps_q ? ST_RD_DST : ST_UPD;
            ST_RD_DST: if (mem_ack) state_d = ST_CMP;
            ST_CMP: begin
                zf_d    = cmps_zf;
                state_d = ST_UPD;
            end
            ST_UPD: begin
                esi_d = esi_step;
                if (cmps_q)  edi_d = edi_step;
                if (rep_act) ecx_d = ecx_q - CNT_W'(1);
                state_d = stop ? ST_DONE : ST_RD_SRC;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            esi_q      <= '0;
            edi_q      <= '0;
            ecx_q      <= '0;
            cmps_q     <= 1'b0;
            rep_q      <= REP_NONE;
            size_q     <= SZ_BYTE;
            df_q       <= 1'b0;
            zf_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            flags_ld_q <= 1'b0;
            wb_en_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            esi_q      <= esi_d;
            edi_q      <= edi_d;
            ecx_q      <= ecx_d;
            cmps_q     <= cmps_d;
            rep_q      <= rep_d;
            size_q     <= size_d;
            df_q       <= df_d;
            zf_q       <= zf_d;
            busy_q     <= (state_d != ST_IDLE);
            done_q     <= (state_d == ST_DONE);
            wb_en_q    <= (state_d == ST_DONE);
            flags_ld_q <= (state_d == ST_CMP);
            mem_req_q  <= (state_d == ST_RD_SRC) || (state_d == ST_RD_DST);
            mem_addr_q <= (state_d == ST_RD_SRC) ? esi_d :
                          (state_d == ST_RD_DST) ? edi_d : '0;
        end
    end

    // Source capture must coincide with the ack cycle, so this one is decoded.
    assign latch_en    = (state_q == ST_RD_SRC) && mem_ack;
    assign busy        = busy_q;
    assign done        = done_q;
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign mem_rd_size = size_q;
    assign flags_ld    = flags_ld_q;
    assign wb_en       = wb_en_q;
    assign esi_out     = esi_q;
    assign edi_out     = edi_q;
    assign ecx_out     = ecx_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rep_str_seq.sv
// Directed bench for rep_str_seq: a memory responder with an expected-address
// queue, directed string operations, reset abort, and a final report.
module tb_rep_str_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        op_cmps;
    logic [1:0]  rep_mode;
    logic [1:0]  op_size;
    logic        df;
    logic [31:0] esi_in, edi_in, ecx_in;
    logic        mem_ack;
    logic        cmps_zf;
    logic        busy, done, mem_req, latch_en, flags_ld, wb_en;
    logic [31:0] mem_addr, esi_out, edi_out, ecx_out;
    logic [1:0]  mem_rd_size;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    logic        zf_list[$];
    int          ack_dly = 0;
    int          wait_cnt = 0;
    int          flags_cnt = 0;
    int          req_cnt = 0;
    int          latch_cnt = 0;

    rep_str_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op_cmps     (op_cmps),
        .rep_mode    (rep_mode),
        .op_size     (op_size),
        .df          (df),
        .esi_in      (esi_in),
        .edi_in      (edi_in),
        .ecx_in      (ecx_in),
        .mem_ack     (mem_ack),
        .cmps_zf     (cmps_zf),
        .busy        (busy),
        .done        (done),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rd_size (mem_rd_size),
        .latch_en    (latch_en),
        .flags_ld    (flags_ld),
        .esi_out     (esi_out),
        .edi_out     (edi_out),
        .ecx_out     (ecx_out),
        .wb_en       (wb_en),
        .dbg_state_o (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory responder and scoreboard of read addresses
    always @(negedge clk) begin
        if (mem_req === 1'b1) begin
            if (wait_cnt >= ack_dly) begin
                mem_ack  = 1'b1;
                wait_cnt = 0;
                if (exp_q.size() > 0) chk("rd_addr", mem_addr, exp_q.pop_front());
                else                  chk("extra_req", {31'd0, mem_req}, 32'd0);
            end else begin
                mem_ack = 1'b0;
                wait_cnt++;
                if (exp_q.size() > 0) chk("hold_addr", mem_addr, exp_q[0]);
            end
        end else begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end
        if (flags_ld === 1'b1) cmps_zf = (zf_list.size() > 0) ? zf_list.pop_front() : 1'b0;
        if (flags_ld === 1'b1) flags_cnt++;
        if (mem_req === 1'b1)  req_cnt++;
    end

    always @(negedge clk) begin
        #1;
        if (latch_en === 1'b1) latch_cnt++;
    end

    task automatic run_op(input logic cmps, input logic [1:0] rep, input logic [1:0] sz,
                          input logic d, input logic [31:0] si, input logic [31:0] di,
                          input logic [31:0] cx, output int cyc);
        op_cmps  = cmps;
        rep_mode = rep;
        op_size  = sz;
        df       = d;
        esi_in   = si;
        edi_in   = di;
        ecx_in   = cx;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (done !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
    endtask

    int cyc, f0, r0, l0;

    initial begin
        rst_n = 1'b0; start = 1'b0; op_cmps = 1'b0; rep_mode = 2'b00; op_size = 2'b00;
        df = 1'b0; esi_in = '0; edi_in = '0; ecx_in = '0; mem_ack = 1'b0; cmps_zf = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_ecx", ecx_out, 32'd0);
        chk("rst_state", {29'd0, dbg_state}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Non-rep CMPS dword, minimum latency
        f0 = flags_cnt;
        exp_q.push_back(32'h100); exp_q.push_back(32'h200); zf_list.push_back(1'b1);
        run_op(1'b1, 2'b00, 2'b10, 1'b0, 32'h100, 32'h200, 32'd7, cyc);
        chk("t1_latency", cyc, 32'd6);
        chk("t1_esi", esi_out, 32'h104);
        chk("t1_edi", edi_out, 32'h204);
        chk("t1_ecx", ecx_out, 32'd7);
        chk("t1_wb", {31'd0, wb_en}, 32'd1);
        chk("t1_size", {30'd0, mem_rd_size}, 32'd2);
        chk("t1_flags", flags_cnt - f0, 32'd1);
        @(negedge clk);
        chk("t1_done_pulse", {31'd0, done}, 32'd0);
        chk("t1_idle_busy", {31'd0, busy}, 32'd0);

        // REPE CMPS byte, ecx=3, ZF=1,1,0
        f0 = flags_cnt;
        exp_q = '{32'h1000, 32'h2000, 32'h1001, 32'h2001, 32'h1002, 32'h2002};
        zf_list = '{1'b1, 1'b1, 1'b0};
        run_op(1'b1, 2'b01, 2'b00, 1'b0, 32'h1000, 32'h2000, 32'd3, cyc);
        chk("t2_latency", cyc, 32'd14);
        chk("t2_ecx", ecx_out, 32'd0);
        chk("t2_esi", esi_out, 32'h1003);
        chk("t2_edi", edi_out, 32'h2003);
        chk("t2_flags", flags_cnt - f0, 32'd3);
        chk("t2_drain", exp_q.size(), 32'd0);
        @(negedge clk);

        // REP with ecx=0: no reads, no flag load
        f0 = flags_cnt; r0 = req_cnt;
        run_op(1'b1, 2'b01, 2'b01, 1'b0, 32'h500, 32'h600, 32'd0, cyc);
        chk("t3_latency", cyc, 32'd2);
        chk("t3_req", req_cnt - r0, 32'd0);
        chk("t3_flags", flags_cnt - f0, 32'd0);
        chk("t3_esi", esi_out, 32'h500);
        chk("t3_ecx", ecx_out, 32'd0);
        @(negedge clk);

        // LODS word, df=1, esi wraps below zero
        f0 = flags_cnt; l0 = latch_cnt;
        exp_q.push_back(32'h0);
        run_op(1'b0, 2'b00, 2'b01, 1'b1, 32'h0, 32'h55, 32'd2, cyc);
        chk("t4_latency", cyc, 32'd4);
        chk("t4_esi", esi_out, 32'hFFFF_FFFE);
        chk("t4_edi", edi_out, 32'h55);
        chk("t4_ecx", ecx_out, 32'd2);
        chk("t4_latch", latch_cnt - l0, 32'd1);
        chk("t4_flags", flags_cnt - f0, 32'd0);
        @(negedge clk);

        // Delayed acks, then reset during the destination-read wait
        ack_dly = 4;
        exp_q.push_back(32'h300); exp_q.push_back(32'h400); zf_list.push_back(1'b1);
        op_cmps = 1'b1; rep_mode = 2'b00; op_size = 2'b10; df = 1'b0;
        esi_in = 32'h300; edi_in = 32'h400; ecx_in = 32'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!(mem_req === 1'b1 && mem_addr === 32'h400) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("t5_dst_req", mem_addr, 32'h400);
        repeat (2) @(negedge clk);
        chk("t5_dst_hold", mem_addr, 32'h400);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_state", {29'd0, dbg_state}, 32'd0);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_req", {31'd0, mem_req}, 32'd0);
        chk("t5_addr", mem_addr, 32'd0);
        chk("t5_esi", esi_out, 32'd0);
        chk("t5_edi", edi_out, 32'd0);
        chk("t5_ecx", ecx_out, 32'd0);
        chk("t5_flags", {31'd0, flags_ld}, 32'd0);
        chk("t5_wb", {31'd0, wb_en}, 32'd0);
        chk("t5_size", {30'd0, mem_rd_size}, 32'd0);
        exp_q.delete();
        zf_list.delete();
        ack_dly = 0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_stay_idle", {29'd0, dbg_state}, 32'd0);

        // rep_mode 10 with ZF=1 on the first iteration, ecx=5
        f0 = flags_cnt;
`ifdef REP_STR_REPNE_EN
        exp_q = '{32'h10, 32'h20};
        zf_list = '{1'b1};
        run_op(1'b1, 2'b10, 2'b00, 1'b0, 32'h10, 32'h20, 32'd5, cyc);
        chk("t6_ecx", ecx_out, 32'd4);
        chk("t6_esi", esi_out, 32'h11);
        chk("t6_flags", flags_cnt - f0, 32'd1);
`else
        exp_q = '{32'h10, 32'h20, 32'h11, 32'h21};
        zf_list = '{1'b1, 1'b0};
        run_op(1'b1, 2'b10, 2'b00, 1'b0, 32'h10, 32'h20, 32'd5, cyc);
        chk("t6_ecx", ecx_out, 32'd3);
        chk("t6_esi", esi_out, 32'h12);
        chk("t6_flags", flags_cnt - f0, 32'd2);
`endif
        chk("t6_drain", exp_q.size(), 32'd0);
        @(negedge clk);

        // Reserved rep_mode 11 behaves as no prefix
        f0 = flags_cnt;
        exp_q = '{32'h40, 32'h50};
        zf_list = '{1'b1};
        run_op(1'b1, 2'b11, 2'b00, 1'b0, 32'h40, 32'h50, 32'd9, cyc);
        chk("t7_ecx", ecx_out, 32'd9);
        chk("t7_esi", esi_out, 32'h41);
        chk("t7_edi", edi_out, 32'h51);
        chk("t7_flags", flags_cnt - f0, 32'd1);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
